// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package if_prefetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFull
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] WORD_INC         = 32'd4;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Show-ahead FIFO of {pc, inst} pairs with push, pop, synchronous flush and entry count.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [63:0]     data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [63:0]     data_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Pointer and count update; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i) begin
        count_d = count_q + CntW'(1);
      end else if (!push_i && pop_i) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, outputs are gated by empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Head entry presented combinationally, zero when empty.
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CntW'(DEPTH));
    count_o = count_q;
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: fetches sequential words from a combinational instruction
// memory into a small FIFO and presents the head entry to the core. Redirects flush the
// FIFO and restart fetching at the new aligned address.
// Optional macro IF_PREFETCH_BYPASS_EN: when the FIFO is empty the word being fetched is
// presented to the core in the same cycle and, if taken, is not stored.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int unsigned CntW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_in,
  input  logic            reset,
  output logic [31:0]     im_addr,
  output logic            im_r,
  input  logic [31:0]     im_inst,
  output logic            fetch_valid,
  output logic [31:0]     fetch_pc,
  output logic [31:0]     fetch_inst,
  input  logic            fetch_ready,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  output logic [CntW-1:0] occupancy
);

  state_e          state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;

  logic            fetch_en;
  logic            fifo_pop;
  logic            fifo_push;
  logic            byp_take;
  logic [63:0]     fifo_data;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  if_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .data_i  ({fetch_addr_q, im_inst}),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Fetch/pop handshake. A pop frees a slot in the same cycle, so a full FIFO keeps fetching
  // while the core drains it; redirect suppresses both sides.
  always_comb begin
    fetch_en = (state_q != StBoot) && !redirect;
    fifo_pop = !fifo_empty && fetch_ready && !redirect;
    im_r     = fetch_en && (!fifo_full || fifo_pop);
    im_addr  = fetch_addr_q;
    occupancy = fifo_count;
`ifdef IF_PREFETCH_BYPASS_EN
    fetch_valid = !fifo_empty || fetch_en;
    byp_take    = fifo_empty && fetch_en && fetch_ready;
    fetch_pc    = fifo_empty ? (fetch_en ? fetch_addr_q : '0) : fifo_data[63:32];
    fetch_inst  = fifo_empty ? (fetch_en ? im_inst : '0) : fifo_data[31:0];
`else
    fetch_valid = !fifo_empty;
    byp_take    = 1'b0;
    fetch_pc    = fifo_data[63:32];
    fetch_inst  = fifo_data[31:0];
`endif
    fifo_push = im_r && !byp_take;
  end

  // Next fetch address and FSM state.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    state_d      = state_q;
    if (redirect) begin
      fetch_addr_d = align_word(redirect_pc);
      state_d      = StRun;
    end else begin
      if (im_r) fetch_addr_d = fetch_addr_q + WORD_INC;
      unique case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (fifo_push && !fifo_pop && (fifo_count == CntW'(DEPTH - 1))) state_d = StFull;
        end
        StFull: begin
          if (fifo_pop) state_d = StRun;
        end
        default: state_d = StBoot;
      endcase
    end
  end

  // FSM and fetch address registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= StBoot;
      fetch_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a queue-based reference model is compared against
// the DUT outputs every cycle, with directed scenarios pinning key literal values, then
// randomized ready/redirect/reset traffic.
module tb_if_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [31:0] im_addr;
  logic        im_r;
  logic [31:0] im_inst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  int errors = 0;
  int checks = 0;

  if_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_r        (im_r),
    .im_inst     (im_inst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_inst  (fetch_inst),
    .fetch_ready (fetch_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .occupancy   (occupancy)
  );

  always #5 clk_in = ~clk_in;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign im_inst = imem(im_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue of {pc, inst}, plus the next fetch address.
  logic [63:0] m_q[$];
  logic [31:0] m_addr   = RESET_PC;
  bit          m_booted = 1'b0;

  task automatic model_eval(output logic v, output logic [31:0] pc, output logic [31:0] inst,
                            output logic ir, output bit pop, output bit take);
    bit en;
    en   = m_booted && !redirect;
    pop  = (m_q.size() > 0) && fetch_ready && !redirect;
    ir   = en && ((m_q.size() < DEPTH) || pop);
    take = 1'b0;
    v    = m_q.size() > 0;
    pc   = v ? m_q[0][63:32] : 32'h0;
    inst = v ? m_q[0][31:0] : 32'h0;
`ifdef IF_PREFETCH_BYPASS_EN
    if (m_q.size() == 0 && en) begin
      v    = 1'b1;
      pc   = m_addr;
      inst = imem(m_addr);
      take = fetch_ready;
    end
`endif
  endtask

  // Model state update on the clock or asynchronous reset.
  initial begin
    forever begin
      logic        v, ir;
      logic [31:0] pc, inst;
      bit          pop, take;
      @(posedge clk_in or negedge reset);
      if (!reset) begin
        m_q.delete();
        m_addr   = RESET_PC;
        m_booted = 1'b0;
      end else begin
        model_eval(v, pc, inst, ir, pop, take);
        if (redirect) begin
          m_q.delete();
          m_addr = {redirect_pc[31:2], 2'b00};
        end else begin
          if (pop) void'(m_q.pop_front());
          if (ir && !take) m_q.push_back({m_addr, imem(m_addr)});
          if (ir) m_addr = m_addr + 32'd4;
        end
        m_booted = 1'b1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  initial begin
    forever begin
      logic        v, ir;
      logic [31:0] pc, inst;
      bit          pop, take;
      @(negedge clk_in);
      model_eval(v, pc, inst, ir, pop, take);
      chk("model.fetch_valid", 32'(fetch_valid), 32'(v));
      chk("model.fetch_pc", fetch_pc, pc);
      chk("model.fetch_inst", fetch_inst, inst);
      chk("model.occupancy", 32'(occupancy), 32'(m_q.size()));
      chk("model.im_r", 32'(im_r), 32'(ir));
      chk("model.im_addr", im_addr, m_addr);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    fetch_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk_in);
    #1;

    // Reset release with ready high: boot cycle, then sequential fetches.
    reset       = 1'b1;
    fetch_ready = 1'b1;
    @(negedge clk_in);
    chk("boot.im_r", 32'(im_r), 32'h0);
    chk("boot.fetch_valid", 32'(fetch_valid), 32'h0);
    chk("boot.im_addr", im_addr, 32'h0040_0000);
    tick();
    @(negedge clk_in);
    chk("run1.im_r", 32'(im_r), 32'h1);
    chk("run1.im_addr", im_addr, 32'h0040_0000);
    tick();
    @(negedge clk_in);
    chk("seq.pc0", fetch_pc, 32'h0040_0000);
    chk("seq.valid0", 32'(fetch_valid), 32'h1);
    tick();
    @(negedge clk_in);
    chk("seq.pc1", fetch_pc, 32'h0040_0004);
    tick();
    @(negedge clk_in);
    chk("seq.pc2", fetch_pc, 32'h0040_0008);

    // Back-pressure: ready low fills the FIFO and stalls fetching.
    tick();
    fetch_ready = 1'b0;
    pulse_reset();
    repeat (9) tick();
    @(negedge clk_in);
    chk("full.occ", 32'(occupancy), 32'd4);
    chk("full.im_r", 32'(im_r), 32'h0);
    chk("full.pc", fetch_pc, 32'h0040_0000);
    tick();
    fetch_ready = 1'b1;
    @(negedge clk_in);
    chk("drain.im_r", 32'(im_r), 32'h1);
    chk("drain.im_addr", im_addr, 32'h0040_0010);
    tick();
    @(negedge clk_in);
    chk("drain.pc", fetch_pc, 32'h0040_0004);
    chk("drain.occ", 32'(occupancy), 32'd4);

    // Redirect while full to an unaligned target.
    tick();
    fetch_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0103;
    @(negedge clk_in);
    chk("redir.im_r", 32'(im_r), 32'h0);
    tick();
    redirect = 1'b0;
    @(negedge clk_in);
    chk("redir.occ", 32'(occupancy), 32'd0);
    chk("redir.im_addr", im_addr, 32'h0040_0100);
    tick();
    @(negedge clk_in);
    chk("redir.pc", fetch_pc, 32'h0040_0100);

    // Address wrap past the top of the address space.
    tick();
    fetch_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    @(negedge clk_in);
    chk("wrap.im_addr", im_addr, 32'hFFFF_FFF8);
    tick();
    @(negedge clk_in);
    chk("wrap.pc0", fetch_pc, 32'hFFFF_FFF8);
    tick();
    @(negedge clk_in);
    chk("wrap.pc1", fetch_pc, 32'hFFFF_FFFC);
    tick();
    @(negedge clk_in);
    chk("wrap.pc2", fetch_pc, 32'h0000_0000);

    // Asynchronous reset between edges with three entries held.
    tick();
    fetch_ready = 1'b0;
    pulse_reset();
    repeat (4) tick();
    @(negedge clk_in);
    chk("areset.occ_before", 32'(occupancy), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.valid", 32'(fetch_valid), 32'h0);
    chk("areset.occ", 32'(occupancy), 32'd0);
    chk("areset.pc", fetch_pc, 32'h0);
    chk("areset.im_addr", im_addr, 32'h0040_0000);
    #1;
    reset = 1'b1;
    tick();
    @(negedge clk_in);
    chk("areset.restart_im_r", 32'(im_r), 32'h1);
    chk("areset.restart_addr", im_addr, 32'h0040_0000);

    // Randomized traffic with varying ready density, rare redirects and resets.
    for (int seg = 0; seg < 6; seg++) begin
      int unsigned ready_pct;
      ready_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
      for (int i = 0; i < 300; i++) begin
        tick();
        if ($urandom_range(0, 249) == 0) pulse_reset();
        fetch_ready = ($urandom_range(0, 99) < ready_pct);
        redirect    = ($urandom_range(0, 24) == 0);
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : $urandom;
      end
    end
    tick();
    redirect    = 1'b0;
    fetch_ready = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0040_0000, first fetch address after reset.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 im_addr  output  32  instruction memory read address (combinational read, data same cycle).
REQ-006 im_r  output  1  instruction memory read enable.
REQ-007 im_inst  input  32  instruction word returned for im_addr.
REQ-008 fetch_valid  output  1  head entry presented to core.
REQ-009 fetch_pc  output  32  PC of head entry.
REQ-010 fetch_inst  output  32  instruction of head entry.
REQ-011 fetch_ready  input  1  core consumes head when fetch_valid && fetch_ready.
REQ-012 redirect  input  1  branch/jump/exception redirect, single-cycle pulse.
REQ-013 redirect_pc  input  32  new fetch address.
REQ-014 occupancy  output  $clog2(DEPTH+1)  current FIFO entry count.

Function
REQ-015 FSM states: BOOT (first cycle after reset release, no fetch), RUN (fetching), FULL (FIFO full, no fetch); BOOT->RUN unconditionally.
REQ-016 In RUN, im_r=1 and im_addr=fetch_addr; {fetch_addr, im_inst} pushed at clock edge; fetch_addr += 4.
REQ-017 Push permitted when occupancy<DEPTH or a pop occurs same cycle; otherwise im_r=0, fetch_addr held, state FULL.
REQ-018 FULL->RUN in the cycle a pop occurs; RUN->FULL when the push fills the FIFO with no pop.
REQ-019 fetch_valid = (occupancy!=0); fetch_pc/fetch_inst show head entry; 0 when empty.
REQ-020 Pop on fetch_valid && fetch_ready; simultaneous push and pop leaves occupancy unchanged.
REQ-021 fetch_addr increment wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 redirect has priority over everything: FIFO flushed (occupancy=0), no push, no pop acknowledged, im_r=0, fetch_addr <= {redirect_pc[31:2],2'b00}, state -> RUN.
REQ-023 During the redirect cycle fetch_valid is still driven from pre-flush contents; core must ignore it.
REQ-024 Redirect while FULL or BOOT behaves identically to REQ-022.
REQ-025 Latency without bypass: address fetched in cycle N appears on fetch_valid in cycle N+1.

Reset
REQ-026 On reset low: state BOOT, fetch_addr=RESET_PC, occupancy=0, FIFO pointers 0, fetch_valid=0, fetch_pc=0, fetch_inst=0, im_r=0, im_addr=RESET_PC.
REQ-027 Reset asserted mid-operation discards all entries immediately, independent of clk_in.

Configuration
REQ-028 Macro IF_PREFETCH_BYPASS_EN: when defined, if FIFO empty and im_r=1, fetch_valid=1 with fetch_pc=im_addr, fetch_inst=im_inst in the same cycle; if fetch_ready=1 the word is consumed and not pushed.
REQ-029 Without IF_PREFETCH_BYPASS_EN: no combinational path from im_inst to fetch_* outputs; latency per REQ-025.

Structure
REQ-030 Shared package holds state enum (BOOT, RUN, FULL), RESET_PC default, word-increment constant 4.
REQ-031 One sub-module if_prefetch_fifo (DEPTH x 64-bit show-ahead FIFO, push/pop/flush, count) instantiated once.

Verification
REQ-032 Reset release, fetch_ready=1 -> fetch_pc sequence 0x00400000, 0x00400004, 0x00400008 in consecutive cycles starting cycle 2 (cycle 1 with bypass).
REQ-033 fetch_ready=0 for 10 cycles -> occupancy reaches 4, im_r=0, fetch_pc held at 0x00400000; ready=1 -> one pop per cycle, fetching resumes same cycle.
REQ-034 redirect with redirect_pc=0x00400103 while full -> occupancy 0 next cycle, next fetch_pc 0x00400100.
REQ-035 redirect_pc=0xFFFFFFF8, ready=1 -> fetch_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-036 reset pulsed low between clock edges with occupancy=3 -> fetch_valid=0, occupancy=0 immediately, fetching restarts at RESET_PC.
